fifo_uart_tx: RTL and testbench

Downstream drain stage for the byte FIFO. It pops bytes from the FIFO read port whenever data is available and serializes each byte as an asynchronous UART frame on a single output pin: start bit, 8 data bits LSB first, optional parity, and 1 or 2 stop bits. It is the chip's serial egress for FIFO contents and runs in the same clock domain as the FIFO.

---
 rtl/fifo_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte whenever the FIFO has data and ena is high,
// then serialises it as a UART frame (start, 8 data LSB first, optional parity, 1-2 stop).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    PAR   = 3'd4,
    STOP  = 3'd5
  } state_t;

  function automatic logic parity_bit(input logic [7:0] data);
    logic p;
    p = ^data;
    if (PARITY == 2) begin
      parity_bit = ~p;
    end else begin
      parity_bit = p;
    end
  endfunction

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          rd_en_q, rd_en_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          tick_s;

  // Next-state, counters and the next value of every registered output
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    rd_en_d = 1'b0;
    cnt_d   = cnt_q;
    tick_s  = (baud_q == BAUD_LAST);

    if (state_q inside {START, DATA, PAR, STOP}) begin
      baud_d = tick_s ? '0 : baud_q + BW'(1);
    end else begin
      baud_d = '0;
    end

    case (state_q)
      IDLE: begin
        // rd_en_q high means the pop strobe is on the bus this cycle
        if (rd_en_q) begin
          state_d = FETCH;
        end else if (ena && !fifo_empty) begin
          rd_en_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        shift_d = fifo_rdata;
        par_d   = parity_bit(fifo_rdata);
        bit_d   = 3'd0;
        state_d = START;
      end
      START: begin
        if (tick_s) begin
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = HAS_PAR ? PAR : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          shift_d = shift_q;
        end
      end
      PAR: begin
        if (tick_s) begin
          bit_d   = 3'd0;
          state_d = STOP;
        end else begin
          state_d = PAR;
        end
      end
      STOP: begin
        if (tick_s) begin
          if (bit_q == STOP_LAST) begin
            // Pop decision made here so the next strobe lands in the first IDLE cycle
            bit_d   = 3'd0;
            cnt_d   = cnt_q + 8'd1;
            rd_en_d = ena && !fifo_empty;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PAR:     tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset forces the line idle immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      rd_en_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      rd_en_q <= rd_en_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: four instances (parity/stop variants) fed by
// behavioural FIFOs; a byte scoreboard is compared against frames decoded from tx.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int PAR_TAB [4] = '{0, 1, 2, 0};
  localparam int STP_TAB [4] = '{1, 1, 1, 2};
  localparam int NB_TAB  [4] = '{10, 11, 11, 11};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ena, fifo_empty, fifo_rd_en, tx, busy;
  logic [7:0] fifo_rdata [4];
  logic [7:0] frame_cnt  [4];
  logic [7:0] mem [4][300];
  int         wp [4];
  int         rp [4];
  int         rd_cnt [4];
  int         exp_cnt [4];
  int         pop_empty;
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(PAR_TAB[g]), .STOP_BITS(STP_TAB[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .ena(ena[g]), .fifo_empty(fifo_empty[g]),
      .fifo_rdata(fifo_rdata[g]), .fifo_rd_en(fifo_rd_en[g]), .tx(tx[g]),
      .busy(busy[g]), .frame_cnt(frame_cnt[g]));
  end

  // Behavioural FIFOs: data appears the cycle after the pop strobe is sampled
  always @(posedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (fifo_rd_en[g] === 1'b1) begin
        if (fifo_empty[g]) pop_empty <= pop_empty + 1;
        fifo_rdata[g] <= mem[g][rp[g] % 300];
        rp[g]         <= rp[g] + 1;
        rd_cnt[g]     <= rd_cnt[g] + 1;
      end
    end
  end

  always_comb begin
    for (int g = 0; g < 4; g++) fifo_empty[g] = (rp[g] >= wp[g]);
  end

  function automatic logic [15:0] exp_frame(input logic [7:0] b, input int pm);
    logic [15:0] f;
    f      = 16'hFFFF;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (pm == 1) f[9] = ^b;
    else if (pm == 2) f[9] = ~^b;
    return f;
  endfunction

  task automatic push(input int k, input logic [7:0] b, input bit expect_out);
    mem[k][wp[k]] = b;
    wp[k] = wp[k] + 1;
    if (expect_out) exp_q.push_back(b);
  endtask

  task automatic wait_rd(input int k, input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (fifo_rd_en[k] === 1'b1) found = 1'b1;
    end
  endtask

  // Starts at the negedge of the pop cycle N; returns at the negedge after the last stop cycle
  task automatic capture_frame(input int k, output logic [15:0] bits, output bit stable,
                               output bit busy_ok, output bit fetch_ok, output bit rd_after);
    bits = 16'hFFFF; stable = 1'b1; busy_ok = 1'b1;
    @(negedge clk);
    fetch_ok = (tx[k] === 1'b1) && (busy[k] === 1'b1) && (fifo_rd_en[k] === 1'b0);
    for (int b = 0; b < NB_TAB[k]; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (c == 0) bits[b] = tx[k];
        else if (tx[k] !== bits[b]) stable = 1'b0;
        if (busy[k] !== 1'b1 || fifo_rd_en[k] !== 1'b0) busy_ok = 1'b0;
      end
    end
    @(negedge clk);
    rd_after = fifo_rd_en[k];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ({tx[k], fifo_rd_en[k], busy[k]} !== 3'b100 || frame_cnt[k] !== 8'h00) begin
          errors++;
          $display("FAIL reset[%0d] cycle %0d: tx=%b rd_en=%b busy=%b cnt=%0d, want 1 0 0 0",
                   k, i, tx[k], fifo_rd_en[k], busy[k], frame_cnt[k]);
        end
      end
      if (i == 9) rst_n = 1'b1;
    end
    exp_cnt = '{default: 0};
  endtask

  task automatic test_basic();
    logic [15:0] bits, want; bit found, st, bo, fo, ra; logic [7:0] e;
    push(0, 8'hA5, 1'b1);
    wait_rd(0, 10, found);
    checks++;
    if (!found) begin errors++; $display("FAIL basic_rd: no rd_en pulse within 10 cycles"); end
    capture_frame(0, bits, st, bo, fo, ra);
    e = exp_q.pop_front(); want = exp_frame(e, 0); exp_cnt[0]++;
    checks++;
    if (bits !== want) begin errors++; $display("FAIL basic_frame: got %h want %h", bits, want); end
    checks++;
    if ({st, bo, fo, ra, busy[0]} !== 5'b11100) begin
      errors++; $display("FAIL basic_timing: stable/busy/fetch/rd_after/busy_end=%b want 11100", {st, bo, fo, ra, busy[0]});
    end
    checks++;
    if (frame_cnt[0] !== 8'(exp_cnt[0]) || rd_cnt[0] !== 1) begin
      errors++; $display("FAIL basic_count: cnt=%0d pops=%0d want %0d 1", frame_cnt[0], rd_cnt[0], exp_cnt[0]);
    end
  endtask

  task automatic test_parity();
    logic [15:0] bits, want; bit found, st, bo, fo, ra; logic [7:0] e;
    for (int k = 1; k <= 2; k++) begin
      push(k, 8'hA5, 1'b1);
      wait_rd(k, 10, found);
      checks++;
      if (!found) begin errors++; $display("FAIL parity_rd[%0d]: no rd_en pulse", k); end
      capture_frame(k, bits, st, bo, fo, ra);
      e = exp_q.pop_front(); want = exp_frame(e, PAR_TAB[k]); exp_cnt[k]++;
      checks++;
      if (bits !== want || bits[9] !== (k == 2)) begin
        errors++; $display("FAIL parity_frame[%0d]: got %h want %h", k, bits, want);
      end
      checks++;
      if ({st, bo, fo, ra, busy[k]} !== 5'b11100 || frame_cnt[k] !== 8'(exp_cnt[k])) begin
        errors++; $display("FAIL parity_timing[%0d]: flags=%b cnt=%0d want 11100 %0d", k, {st, bo, fo, ra, busy[k]}, frame_cnt[k], exp_cnt[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits, want; bit found, st, bo, fo, ra; logic [7:0] e;
    push(3, 8'h00, 1'b1); push(3, 8'hFF, 1'b1); push(3, 8'h3C, 1'b1);
    wait_rd(3, 10, found);
    checks++;
    if (!found) begin errors++; $display("FAIL b2b_rd: no rd_en pulse"); end
    for (int j = 0; j < 3; j++) begin
      capture_frame(3, bits, st, bo, fo, ra);
      e = exp_q.pop_front(); want = exp_frame(e, 0); exp_cnt[3]++;
      checks++;
      if (bits !== want) begin errors++; $display("FAIL b2b_frame[%0d]: got %h want %h", j, bits, want); end
      checks++;
      if ({st, bo, fo, ra, busy[3]} !== {3'b111, (j < 2), 1'b0}) begin
        errors++; $display("FAIL b2b_spacing[%0d]: flags=%b want %b", j, {st, bo, fo, ra, busy[3]}, {3'b111, (j < 2), 1'b0});
      end
    end
    checks++;
    if (frame_cnt[3] !== 8'd3 || rd_cnt[3] !== 3) begin
      errors++; $display("FAIL b2b_count: cnt=%0d pops=%0d want 3 3", frame_cnt[3], rd_cnt[3]);
    end
  endtask

  task automatic test_ena_gate();
    logic [15:0] bits, want; bit found, st, bo, fo, ra; logic [7:0] e; int c0;
    push(0, 8'h96, 1'b1); push(0, 8'h3B, 1'b1);
    wait_rd(0, 10, found);
    checks++;
    if (!found) begin errors++; $display("FAIL ena_rd1: no rd_en pulse"); end
    fork
      begin repeat (19) @(negedge clk); ena[0] = 1'b0; end
    join_none
    capture_frame(0, bits, st, bo, fo, ra);
    e = exp_q.pop_front(); want = exp_frame(e, 0); exp_cnt[0]++;
    checks++;
    if (bits !== want || {st, bo, fo, ra} !== 4'b1110) begin
      errors++; $display("FAIL ena_frame1: got %h flags=%b want %h 1110", bits, {st, bo, fo, ra}, want);
    end
    c0 = rd_cnt[0];
    repeat (30) @(negedge clk);
    checks++;
    if (rd_cnt[0] !== c0 || busy[0] !== 1'b0 || tx[0] !== 1'b1 || frame_cnt[0] !== 8'(exp_cnt[0])) begin
      errors++; $display("FAIL ena_hold: pops=%0d busy=%b tx=%b cnt=%0d want %0d 0 1 %0d", rd_cnt[0], busy[0], tx[0], frame_cnt[0], c0, exp_cnt[0]);
    end
    ena[0] = 1'b1;
    wait_rd(0, 5, found);
    checks++;
    if (!found) begin errors++; $display("FAIL ena_rd2: no rd_en after ena raised"); end
    capture_frame(0, bits, st, bo, fo, ra);
    e = exp_q.pop_front(); want = exp_frame(e, 0); exp_cnt[0]++;
    checks++;
    if (bits !== want || frame_cnt[0] !== 8'(exp_cnt[0])) begin
      errors++; $display("FAIL ena_frame2: got %h cnt=%0d want %h %0d", bits, frame_cnt[0], want, exp_cnt[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] bits, want; bit found, st, bo, fo, ra; logic [7:0] e;
    push(0, 8'hC3, 1'b0);
    push(0, 8'h5A, 1'b1);
    wait_rd(0, 10, found);
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_rd: no rd_en pulse"); end
    repeat (27) @(negedge clk);
    checks++;
    if (tx[0] !== 1'b0) begin errors++; $display("FAIL rstmid_bit5: tx=%b want 0", tx[0]); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx[0], busy[0], fifo_rd_en[0]} !== 3'b100 || frame_cnt[0] !== 8'h00) begin
      errors++; $display("FAIL rstmid_async: tx=%b busy=%b rd_en=%b cnt=%0d want 1 0 0 0", tx[0], busy[0], fifo_rd_en[0], frame_cnt[0]);
    end
    exp_cnt = '{default: 0};
    @(negedge clk);
    rst_n = 1'b1;
    wait_rd(0, 10, found);
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_rd2: no rd_en after reset"); end
    capture_frame(0, bits, st, bo, fo, ra);
    e = exp_q.pop_front(); want = exp_frame(e, 0); exp_cnt[0]++;
    checks++;
    if (bits !== want || {st, bo, fo} !== 3'b111 || frame_cnt[0] !== 8'(exp_cnt[0])) begin
      errors++; $display("FAIL rstmid_frame: got %h cnt=%0d want %h %0d", bits, frame_cnt[0], want, exp_cnt[0]);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] bits, want; bit found, st, bo, fo, ra; logic [7:0] e;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '{default: 0};
    for (int j = 0; j < 256; j++) push(0, 8'h55, 1'b1);
    wait_rd(0, 10, found);
    checks++;
    if (!found) begin errors++; $display("FAIL wrap_rd: no rd_en pulse"); end
    for (int j = 0; j < 256; j++) begin
      capture_frame(0, bits, st, bo, fo, ra);
      e = exp_q.pop_front(); want = exp_frame(e, 0); exp_cnt[0]++;
      checks++;
      if (bits !== want || ra !== (j < 255)) begin
        errors++; $display("FAIL wrap_frame[%0d]: got %h rd_after=%b want %h %b", j, bits, ra, want, (j < 255));
      end
      checks++;
      if (frame_cnt[0] !== 8'(exp_cnt[0])) begin
        errors++; $display("FAIL wrap_count[%0d]: cnt=%0d want %0d", j, frame_cnt[0], 8'(exp_cnt[0]));
      end
    end
    checks++;
    if (frame_cnt[0] !== 8'h00 || exp_q.size() != 0) begin
      errors++; $display("FAIL wrap_final: cnt=%0d pending=%0d want 0 0", frame_cnt[0], exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 4'hF;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_ena_gate();
    test_reset_mid();
    test_wrap();
    checks++;
    if (pop_empty != 0) begin errors++; $display("FAIL pop_while_empty: %0d pops want 0", pop_empty); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
